cp0_ctrl_param: RTL and testbench
=================================

// Module: cp0_ctrl_param
// PURPOSE
//  Parametrised CP0 for the 5-stage MIPS core. Holds BadVAddr, Count, Compare, Status, Cause and EPC.
//  Adds a prescaled Count/Compare timer interrupt (Cause.TI), configurable external IRQ width,
//  an IRQ synchroniser and software interrupts. Sits at the WB commit point.
//  Drives the flush/redirect (vector or EPC) and the mfc0 read data.
// PARAMETERS
//  NUM_EXT_INT  6             number of ext_int lines, 1..6; missing IP lines are tied to 0
//  SYNC_STAGES  2             synchroniser flops on ext_int, 0..2; 0 = used directly
//  COUNT_DIV    2             Count increments once every COUNT_DIV clocks, >=1
//  EXC_VECTOR   32'hBFC00380  exception/interrupt redirect target
//  TIMER_IP7    1             1 = Cause.TI is ORed into IP7
// PORTS
//  clk           in   1            clock
//  rst_n         in   1            asynchronous active-low reset
//  wb_valid      in   1            valid instruction committing this cycle
//  wb_exception  in   1            pipeline exception on the committing instruction
//  wb_exccode    in   5            ExcCode of wb_exception
//  wb_bd         in   1            committing instruction is in a delay slot
//  wb_pc         in   32           PC of the committing instruction
//  wb_badvaddr   in   32           faulting virtual address (AdEL/AdES)
//  wb_eret       in   1            committing instruction is ERET
//  wb_mtc0       in   1            committing instruction is MTC0
//  wb_cp0_addr   in   8            {rd[4:0],sel[2:0]} of MFC0/MTC0
//  wb_wdata      in   32           MTC0 write data
//  ext_int       in   NUM_EXT_INT  external interrupt levels, asynchronous
//  cp0_rdata     out  32           MFC0 read data, combinational on wb_cp0_addr
//  flush         out  1            pipeline clear and redirect, combinational in the commit cycle
//  flush_pc      out  32           EXC_VECTOR for exception/interrupt, EPC for ERET
//  int_pending   out  1            an interrupt will be taken at the next valid commit
//  timer_int     out  1            Cause.TI
// BEHAVIOUR
//  Register map (addr 8'h..), with reset values:
//   BadVAddr 40, reset 0.
//   Count 48, reset 0.
//   Compare 58, reset 0.
//   Status 60, reset 32'h0040_0000: BEV[22] read-only 1; IM[15:8] rw; EXL[1] rw; IE[0] rw; other bits read 0.
//   Cause 68, reset 0: BD[31] ro; TI[30] ro; IP[15:10] ro (hardware); IP[9:8] rw (software); ExcCode[6:2] ro.
//   EPC 70, reset 0.
//   Unmapped addresses read 0 and ignore writes.
//  Output reset values: flush=0, flush_pc=EXC_VECTOR, timer_int=0, int_pending=0.
//  IP[15:10] = sync(ext_int) zero-extended to 6 bits; IP7 additionally |= TI when TIMER_IP7=1.
//  int_pending = |(IP & IM) & IE & !EXL.
//  Commit priority (one event per cycle; a lower-priority event is suppressed):
//   1. Interrupt: wb_valid & int_pending. ExcCode=0.
//   2. Exception: wb_valid & wb_exception.
//   3. ERET: wb_valid & wb_eret. EXL<=0, flush_pc=EPC, using the pre-update EPC.
//   4. MTC0: wb_valid & wb_mtc0. Writes the rw fields at the clock edge.
//  On interrupt or exception:
//   - If EXL=0: EPC <= wb_bd ? wb_pc-4 : wb_pc, and Cause.BD <= wb_bd.
//   - If EXL=1: EPC and BD are left unchanged.
//   - Always: EXL <= 1, ExcCode updated, flush=1, flush_pc=EXC_VECTOR.
//   - BadVAddr <= wb_badvaddr only for ExcCode 4 (AdEL) or 5 (AdES), and never on an interrupt.
//  wb_valid=0: no state changes except the timer and IRQ sampling; flush=0.
//  Timer:
//   - Prescaler counts 0..COUNT_DIV-1; Count increments (mod 2^32) on the wrap tick.
//   - TI is set on the edge where the new Count equals Compare.
//   - An MTC0 to Count overrides that edge's increment and resets the prescaler.
//   - An MTC0 to Compare clears TI; the write wins over a same-edge match.
//   - TI stays set otherwise; Count wraps FFFF_FFFF -> 0 silently.
//  MFC0 returns pre-edge values, so an MTC0 followed by MFC0 in the next cycle sees the new value.
//  Reset mid-operation: all registers return to their reset values immediately; the synchroniser is cleared.
// TESTING
//  1. Reset; read 60/68/48 -> 0040_0000 / 0 / 0; after 10 clocks with COUNT_DIV=2, Count=5.
//  2. MTC0 Compare=3, Status=0000_8001; wait until Count=3
//     -> TI=1, IP7=1, int_pending=1.
//     Next valid commit at pc BFC0_0100 -> flush=1, flush_pc=BFC0_0380, EPC=BFC0_0100, EXL=1, ExcCode=0.
//     Then MTC0 Compare -> TI=0.
//  3. AdEL (ExcCode 4) with bd=1, pc 8000_0010, badvaddr 0000_0003
//     -> EPC=8000_000C, BD=1, BadVAddr=0000_0003.
//     A second exception while EXL=1 leaves EPC unchanged.
//  4. ERET with EPC=8000_0020 -> flush=1, flush_pc=8000_0020, EXL=0.
//     Same-cycle interrupt pending -> interrupt wins, flush_pc=BFC0_0380.
//  5. MTC0 Cause=0000_0100 with IM0=1, IE=1 -> software interrupt taken at the next commit.
//     ext_int[0] pulse with SYNC_STAGES=2 -> IP2 is visible 2 clocks later.
//  6. MTC0 to Count at a prescaler tick -> Count=write data, no increment.
//     Count=FFFF_FFFF -> wraps to 0.
//     rst_n low mid-operation -> all registers return to reset values asynchronously.

Source files
------------

// File: rtl/cp0_ctrl_param_if.sv
// Commit-point bundle between the WB stage and CP0.
// The pipeline drives the wb_* fields; CP0 returns the redirect, the read data and the interrupt status.
interface cp0_ctrl_param_if;
    logic        wb_valid;
    logic        wb_exception;
    logic [4:0]  wb_exccode;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        wb_eret;
    logic        wb_mtc0;
    logic [7:0]  wb_cp0_addr;
    logic [31:0] wb_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        int_pending;
    logic        timer_int;

    modport master (
        output wb_valid, wb_exception, wb_exccode, wb_bd, wb_pc, wb_badvaddr,
               wb_eret, wb_mtc0, wb_cp0_addr, wb_wdata,
        input  cp0_rdata, flush, flush_pc, int_pending, timer_int
    );

    modport slave (
        input  wb_valid, wb_exception, wb_exccode, wb_bd, wb_pc, wb_badvaddr,
               wb_eret, wb_mtc0, wb_cp0_addr, wb_wdata,
        output cp0_rdata, flush, flush_pc, int_pending, timer_int
    );
endinterface

// File: rtl/cp0_ctrl_param.sv
// Parametrised CP0 for the 5-stage MIPS core: BadVAddr, Count/Compare timer, Status, Cause, EPC.
// Commits one event per cycle at WB and drives the flush/redirect and MFC0 read data.
module cp0_ctrl_param #(
    parameter int          NUM_EXT_INT = 6,
    parameter int          SYNC_STAGES = 2,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
    parameter bit          TIMER_IP7   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_EXT_INT-1:0] ext_int,
    cp0_ctrl_param_if.slave        bus
);

    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;
    localparam logic [31:0] PRESC_LAST   = 32'(COUNT_DIV - 1);

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] presc_q, presc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;

    logic [NUM_EXT_INT-1:0] ext_sync;
    logic [5:0]  ip_hw;
    logic [7:0]  ip_all;
    logic        int_pend;
    logic        take_int, take_exc, take_eret, do_mtc0;
    logic        tick;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ext_sync = ext_int;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NUM_EXT_INT-1:0] sync_q, sync_d;

            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = ext_int;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign ext_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        ip_hw                  = '0;
        ip_hw[NUM_EXT_INT-1:0] = ext_sync;
        if (TIMER_IP7) begin
            ip_hw[5] = ip_hw[5] | ti_q;
        end
    end

    assign ip_all   = {ip_hw, ip_sw_q};
    assign int_pend = (|(ip_all & im_q)) & ie_q & ~exl_q;

    // One commit event per cycle, highest priority first.
    assign take_int  = bus.wb_valid & int_pend;
    assign take_exc  = bus.wb_valid & bus.wb_exception & ~take_int;
    assign take_eret = bus.wb_valid & bus.wb_eret & ~take_int & ~bus.wb_exception;
    assign do_mtc0   = bus.wb_valid & bus.wb_mtc0 & ~take_int & ~bus.wb_exception & ~bus.wb_eret;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        presc_d    = tick ? 32'd0 : presc_q + 32'd1;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;

        if (tick) begin
            count_d = count_q + 32'd1;
        end

        if (take_int || take_exc) begin
            if (!exl_q) begin
                epc_d = bus.wb_bd ? bus.wb_pc - 32'd4 : bus.wb_pc;
                bd_d  = bus.wb_bd;
            end
            exl_d     = 1'b1;
            exccode_d = take_int ? 5'd0 : bus.wb_exccode;
            if (take_exc && (bus.wb_exccode == 5'd4 || bus.wb_exccode == 5'd5)) begin
                badvaddr_d = bus.wb_badvaddr;
            end
        end else if (take_eret) begin
            exl_d = 1'b0;
        end else if (do_mtc0) begin
            // BadVAddr and the hardware-owned Cause fields are not writable.
            case (bus.wb_cp0_addr)
                ADDR_COUNT: begin
                    count_d = bus.wb_wdata;
                    presc_d = 32'd0;
                end
                ADDR_COMPARE: compare_d = bus.wb_wdata;
                ADDR_STATUS: begin
                    im_d  = bus.wb_wdata[15:8];
                    exl_d = bus.wb_wdata[1];
                    ie_d  = bus.wb_wdata[0];
                end
                ADDR_CAUSE: ip_sw_d = bus.wb_wdata[9:8];
                ADDR_EPC:   epc_d   = bus.wb_wdata;
                default: ;
            endcase
        end

        // A Compare write clears TI even if Count lands on Compare on the same edge.
        if (do_mtc0 && bus.wb_cp0_addr == ADDR_COMPARE) begin
            ti_d = 1'b0;
        end else if ((tick || (do_mtc0 && bus.wb_cp0_addr == ADDR_COUNT)) && count_d == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            presc_q    <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            presc_q    <= presc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
        end
    end

    always_comb begin
        bus.cp0_rdata = 32'd0;
        case (bus.wb_cp0_addr)
            ADDR_BADVADDR: bus.cp0_rdata = badvaddr_q;
            ADDR_COUNT:    bus.cp0_rdata = count_q;
            ADDR_COMPARE:  bus.cp0_rdata = compare_q;
            ADDR_STATUS:   bus.cp0_rdata = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
            ADDR_CAUSE:    bus.cp0_rdata = {bd_q, ti_q, 14'd0, ip_all, 1'b0, exccode_q, 2'd0};
            ADDR_EPC:      bus.cp0_rdata = epc_q;
            default:       bus.cp0_rdata = 32'd0;
        endcase
    end

    assign bus.flush       = take_int | take_exc | take_eret;
    assign bus.flush_pc    = take_eret ? epc_q : EXC_VECTOR;
    assign bus.int_pending = int_pend;
    assign bus.timer_int   = ti_q;

endmodule

// File: tb/tb_cp0_ctrl_param.sv
// Self-checking bench for cp0_ctrl_param: expectations are queued as stimulus is driven
// and compared in order against the observations each scenario collects.
module tb_cp0_ctrl_param;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic       clk;
    logic       rst_n;
    logic [5:0] ext_int;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] obs_q[$];

    logic        obs_flush;
    logic [31:0] obs_fpc;

    cp0_ctrl_param_if bus();

    cp0_ctrl_param #(
        .NUM_EXT_INT(6),
        .SYNC_STAGES(2),
        .COUNT_DIV  (2),
        .EXC_VECTOR (VEC),
        .TIMER_IP7  (1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ext_int(ext_int),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input string n, input logic [31:0] v);
        name_q.push_back(n);
        exp_q.push_back(v);
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] d);
        bus.wb_cp0_addr = a;
        #1;
        d = bus.cp0_rdata;
    endtask

    task automatic expect_reg(input string n, input logic [7:0] a, input logic [31:0] v);
        logic [31:0] d;
        expect_val(n, v);
        peek(a, d);
        obs_q.push_back(d);
    endtask

    task automatic commit(input logic exc, input logic [4:0] code, input logic bd,
                          input logic [31:0] pc, input logic [31:0] badv, input logic eret,
                          input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.wb_valid     = 1'b1;
        bus.wb_exception = exc;
        bus.wb_exccode   = code;
        bus.wb_bd        = bd;
        bus.wb_pc        = pc;
        bus.wb_badvaddr  = badv;
        bus.wb_eret      = eret;
        bus.wb_mtc0      = wr;
        bus.wb_cp0_addr  = addr;
        bus.wb_wdata     = wdata;
        #1;
        obs_flush = bus.flush;
        obs_fpc   = bus.flush_pc;
        @(posedge clk);
        #1;
        bus.wb_valid     = 1'b0;
        bus.wb_exception = 1'b0;
        bus.wb_eret      = 1'b0;
        bus.wb_mtc0      = 1'b0;
        bus.wb_bd        = 1'b0;
    endtask

    task automatic write_cp0(input logic [7:0] a, input logic [31:0] d);
        commit(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, a, d);
    endtask

    task automatic drain(input string tname);
        logic [31:0] e;
        logic [31:0] g;
        string       n;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL %s/%s: no observation, want %h", tname, n, e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("[TB] FAIL %s/%s: got %h want %h", tname, n, g, e);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_val("flush", 32'd0);        obs_q.push_back({31'd0, bus.flush});
        expect_val("flush_pc", VEC);       obs_q.push_back(bus.flush_pc);
        expect_val("timer_int", 32'd0);    obs_q.push_back({31'd0, bus.timer_int});
        expect_val("int_pending", 32'd0);  obs_q.push_back({31'd0, bus.int_pending});
        expect_reg("status", 8'h60, 32'h0040_0000);
        expect_reg("cause", 8'h68, 32'h0000_0000);
        expect_reg("count", 8'h48, 32'h0000_0000);
        repeat (10) @(posedge clk);
        #1;
        expect_reg("count_after_10", 8'h48, 32'd5);
        drain("test_reset");
    endtask

    task automatic test_timer();
        logic found;
        write_cp0(8'h48, 32'd0);
        write_cp0(8'h58, 32'd3);
        write_cp0(8'h60, 32'h0000_8001);
        expect_val("int_pending_before", 32'd0); obs_q.push_back({31'd0, bus.int_pending});
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.timer_int === 1'b1) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL timer_wait: timer_int=%b after 40 clocks, want 1", bus.timer_int);
        end
        expect_reg("count_at_ti", 8'h48, 32'd3);
        expect_reg("cause_ti_ip7", 8'h68, 32'h4000_8000);
        expect_val("int_pending", 32'd1); obs_q.push_back({31'd0, bus.int_pending});
        commit(1'b0, 5'd0, 1'b0, 32'hBFC0_0100, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0);
        expect_val("irq_flush", 32'd1);   obs_q.push_back({31'd0, obs_flush});
        expect_val("irq_flush_pc", VEC);  obs_q.push_back(obs_fpc);
        expect_reg("irq_epc", 8'h70, 32'hBFC0_0100);
        expect_reg("irq_status", 8'h60, 32'h0040_8003);
        expect_reg("irq_cause", 8'h68, 32'h4000_8000);
        write_cp0(8'h58, 32'h0000_1000);
        expect_val("ti_cleared", 32'd0); obs_q.push_back({31'd0, bus.timer_int});
        expect_reg("cause_cleared", 8'h68, 32'h0000_0000);
        drain("test_timer");
    endtask

    task automatic test_exception();
        write_cp0(8'h60, 32'h0000_0000);
        commit(1'b1, 5'd4, 1'b1, 32'h8000_0010, 32'h0000_0003, 1'b0, 1'b0, 8'h00, 32'd0);
        expect_val("adel_flush", 32'd1);  obs_q.push_back({31'd0, obs_flush});
        expect_val("adel_flush_pc", VEC); obs_q.push_back(obs_fpc);
        expect_reg("adel_epc", 8'h70, 32'h8000_000C);
        expect_reg("adel_cause", 8'h68, 32'h8000_0010);
        expect_reg("adel_badvaddr", 8'h40, 32'h0000_0003);
        expect_reg("adel_status", 8'h60, 32'h0040_0002);
        commit(1'b1, 5'd5, 1'b0, 32'h8000_0050, 32'h0000_0044, 1'b0, 1'b0, 8'h00, 32'd0);
        expect_reg("nested_epc", 8'h70, 32'h8000_000C);
        expect_reg("nested_cause", 8'h68, 32'h8000_0014);
        expect_reg("nested_badvaddr", 8'h40, 32'h0000_0044);
        drain("test_exception");
    endtask

    task automatic test_eret();
        write_cp0(8'h70, 32'h8000_0020);
        commit(1'b0, 5'd0, 1'b0, 32'h8000_0100, 32'd0, 1'b1, 1'b0, 8'h00, 32'd0);
        expect_val("eret_flush", 32'd1);            obs_q.push_back({31'd0, obs_flush});
        expect_val("eret_flush_pc", 32'h8000_0020); obs_q.push_back(obs_fpc);
        expect_reg("eret_status", 8'h60, 32'h0040_0000);
        write_cp0(8'h68, 32'h0000_0100);
        expect_reg("cause_sw_write", 8'h68, 32'h8000_0114);
        write_cp0(8'h60, 32'h0000_0101);
        expect_val("pend_before_eret", 32'd1); obs_q.push_back({31'd0, bus.int_pending});
        commit(1'b0, 5'd0, 1'b0, 32'h8000_0200, 32'd0, 1'b1, 1'b0, 8'h00, 32'd0);
        expect_val("int_over_eret_flush", 32'd1);  obs_q.push_back({31'd0, obs_flush});
        expect_val("int_over_eret_pc", VEC);       obs_q.push_back(obs_fpc);
        expect_reg("int_over_eret_epc", 8'h70, 32'h8000_0200);
        expect_reg("int_over_eret_status", 8'h60, 32'h0040_0103);
        expect_reg("int_over_eret_cause", 8'h68, 32'h0000_0100);
        drain("test_eret");
    endtask

    task automatic test_interrupts();
        write_cp0(8'h68, 32'h0000_0000);
        write_cp0(8'h60, 32'h0000_0101);
        expect_val("sw_pend_off", 32'd0); obs_q.push_back({31'd0, bus.int_pending});
        write_cp0(8'h68, 32'h0000_0100);
        expect_val("sw_pend_on", 32'd1);  obs_q.push_back({31'd0, bus.int_pending});
        commit(1'b0, 5'd0, 1'b0, 32'h8000_0300, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0);
        expect_val("sw_flush", 32'd1);    obs_q.push_back({31'd0, obs_flush});
        expect_val("sw_flush_pc", VEC);   obs_q.push_back(obs_fpc);
        expect_reg("sw_epc", 8'h70, 32'h8000_0300);
        write_cp0(8'h68, 32'h0000_0000);
        ext_int[0] = 1'b1;
        @(posedge clk);
        #1;
        ext_int[0] = 1'b0;
        expect_reg("ip2_after_1clk", 8'h68, 32'h0000_0000);
        @(posedge clk);
        #1;
        expect_reg("ip2_after_2clk", 8'h68, 32'h0000_0400);
        @(posedge clk);
        #1;
        expect_reg("ip2_after_3clk", 8'h68, 32'h0000_0000);
        drain("test_interrupts");
    endtask

    task automatic test_count_and_reset();
        write_cp0(8'h48, 32'd100);
        @(posedge clk);
        #1;
        write_cp0(8'h48, 32'h0000_0200);
        expect_reg("count_write_tick", 8'h48, 32'h0000_0200);
        @(posedge clk);
        #1;
        expect_reg("count_hold", 8'h48, 32'h0000_0200);
        @(posedge clk);
        #1;
        expect_reg("count_inc", 8'h48, 32'h0000_0201);
        write_cp0(8'h48, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        expect_reg("count_max", 8'h48, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        expect_reg("count_wrap", 8'h48, 32'h0000_0000);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        expect_reg("rst_count", 8'h48, 32'd0);
        expect_reg("rst_status", 8'h60, 32'h0040_0000);
        expect_reg("rst_epc", 8'h70, 32'd0);
        expect_reg("rst_badvaddr", 8'h40, 32'd0);
        expect_reg("rst_compare", 8'h58, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain("test_count_and_reset");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ext_int = '0;
        bus.wb_valid     = 1'b0;
        bus.wb_exception = 1'b0;
        bus.wb_exccode   = 5'd0;
        bus.wb_bd        = 1'b0;
        bus.wb_pc        = 32'd0;
        bus.wb_badvaddr  = 32'd0;
        bus.wb_eret      = 1'b0;
        bus.wb_mtc0      = 1'b0;
        bus.wb_cp0_addr  = 8'h00;
        bus.wb_wdata     = 32'd0;
        test_reset();
        test_timer();
        test_exception();
        test_eret();
        test_interrupts();
        test_count_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
